// File: rtl/im.sv
// Instruction memory: big-endian byte store with a combinational fetch path and a synchronous load port.
// Fetch has zero clock latency, and a load is visible after its clock edge; the block never backpressures.
module im #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] busPc,
  input  logic        wr_en,
  input  logic [63:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] instruction,
  output logic        pc_fault
);

  localparam int NBYTES = 4 * DEPTH_WORDS;
  localparam int AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [7:0]    mem_q [NBYTES];
  logic [7:0]    mem_d [NBYTES];

  logic          rd_in_range;
  logic          wr_in_range;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          wr_unused;

  // The range checks use the full upper address, so any high bit faults instead of wrapping.
  assign rd_in_range = (busPc[63:2] < 62'(DEPTH_WORDS));
  assign wr_in_range = (wr_addr[63:2] < 62'(DEPTH_WORDS));
  assign rd_idx      = busPc[AW+1:2];
  assign wr_idx      = wr_addr[AW+1:2];
  assign wr_unused   = ^wr_addr[1:0];

  always_comb begin
    instruction = 32'h0000_0000;
    if (rd_in_range) begin
      instruction = {mem_q[{rd_idx, 2'd0}], mem_q[{rd_idx, 2'd1}],
                     mem_q[{rd_idx, 2'd2}], mem_q[{rd_idx, 2'd3}]};
    end
    pc_fault = (busPc[1:0] != 2'b00) || !rd_in_range;
  end

  always_comb begin
    mem_d = mem_q;
    if (reset) begin
      mem_d = '{default: 8'h00};
    end else if (wr_en && wr_in_range) begin
      mem_d[{wr_idx, 2'd0}] = wr_data[31:24];
      mem_d[{wr_idx, 2'd1}] = wr_data[23:16];
      mem_d[{wr_idx, 2'd2}] = wr_data[15:8];
      mem_d[{wr_idx, 2'd3}] = wr_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_im.sv
// Directed bench for im: expected fetch results are queued as stimulus is applied and checked as the outputs settle.
module tb_im;

  logic        clk;
  logic        reset;
  logic [63:0] busPc;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] instruction;
  logic        pc_fault;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] sb_instr [$];
  logic        sb_fault [$];
  string       sb_tag   [$];

  logic [31:0] model [8];

  im #(.DEPTH_WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .busPc      (busPc),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .instruction(instruction),
    .pc_fault   (pc_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic compare_out();
    logic [31:0] ei;
    logic        ef;
    string       tag;
    ei  = sb_instr.pop_front();
    ef  = sb_fault.pop_front();
    tag = sb_tag.pop_front();
    tests_run++;
    assert (instruction === ei) else begin
      tests_failed++;
      $error("FAIL %s instruction got=%h exp=%h", tag, instruction, ei);
    end
    tests_run++;
    assert (pc_fault === ef) else begin
      tests_failed++;
      $error("FAIL %s pc_fault got=%b exp=%b", tag, pc_fault, ef);
    end
  endtask

  task automatic expect_read(input logic [63:0] pc, input logic [31:0] ei,
                             input logic ef, input string tag);
    busPc = pc;
    sb_instr.push_back(ei);
    sb_fault.push_back(ef);
    sb_tag.push_back(tag);
    #1;
    compare_out();
  endtask

  task automatic write_word(input logic [63:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 64'd0;
    wr_data = 32'd0;
    busPc   = 64'd0;
    @(posedge clk);
    #1 reset = 1'b0;
    #20;
    expect_read(64'd0,   32'h0000_0000, 1'b0, "reset_pc0");
    expect_read(64'd252, 32'h0000_0000, 1'b0, "reset_pc252");

    write_word(64'd0, 32'hF840_0020);
    write_word(64'd4, 32'h8B02_0023);
    expect_read(64'd0, 32'hF840_0020, 1'b0, "read_w0");
    expect_read(64'd4, 32'h8B02_0023, 1'b0, "read_w1");
    expect_read(64'd6, 32'h8B02_0023, 1'b1, "misaligned_6");
    expect_read(64'd1, 32'hF840_0020, 1'b1, "misaligned_1");

    expect_read(64'd256, 32'h0000_0000, 1'b1, "oor_256");
    expect_read(64'h8000_0000_0000_0000, 32'h0000_0000, 1'b1, "oor_msb");
    expect_read(64'h0000_0001_0000_0000, 32'h0000_0000, 1'b1, "oor_wrap");
    write_word(64'd256, 32'hFFFF_FFFF);
    write_word(64'h0000_0001_0000_0000, 32'hAAAA_5555);
    expect_read(64'd0, 32'hF840_0020, 1'b0, "oor_write_w0");

    write_word(64'd252, 32'h1234_5678);
    expect_read(64'd252, 32'h1234_5678, 1'b0, "last_word");
    expect_read(64'd255, 32'h1234_5678, 1'b1, "last_word_mis");

    write_word(64'd11, 32'h0BAD_CAFE);
    expect_read(64'd8, 32'h0BAD_CAFE, 1'b0, "wr_addr_lsb_ignored");

    // Old data must be visible right up to the write edge.
    busPc = 64'd20;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 64'd20; wr_data = 32'hCAFE_F00D;
    #1 expect_read(64'd20, 32'h0000_0000, 1'b0, "pre_edge_old");
    @(posedge clk);
    #1 wr_en = 1'b0;
    expect_read(64'd20, 32'hCAFE_F00D, 1'b0, "post_edge_new");

    repeat (5) @(posedge clk);
    #1 expect_read(64'd20, 32'hCAFE_F00D, 1'b0, "hold");

    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      write_word(64'(128 + 4 * i), model[i]);
    end
    for (int i = 0; i < 8; i++) begin
      expect_read(64'(128 + 4 * i), model[i], 1'b0, $sformatf("bulk_%0d", i));
    end

    // Reset and write on the same edge: the write is lost and everything clears.
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b1; wr_addr = 64'd8; wr_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 reset = 1'b0; wr_en = 1'b0;
    expect_read(64'd8,   32'h0000_0000, 1'b0, "rst_wr_pc8");
    expect_read(64'd0,   32'h0000_0000, 1'b0, "rst_clear_w0");
    expect_read(64'd252, 32'h0000_0000, 1'b0, "rst_clear_last");
    expect_read(64'd132, 32'h0000_0000, 1'b0, "rst_clear_bulk");
    expect_read(64'd6,   32'h0000_0000, 1'b1, "rst_fault_6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
